// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter.
//   REG_ADDR_W / DATA_W / REG_COUNT size the architectural register file;
//   wr_req_t is the {addr, data} write record used by the arbiter and the
//   long-latency result FIFO.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  // Register 0 is hardwired; writes to it are dropped everywhere.
  function automatic logic is_live_addr(input logic [REG_ADDR_W-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_lu_result_fifo.sv
// lu_result_fifo
//   Synchronous FIFO buffering long-latency unit results until the
//   register-file write port is free.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data   write one entry (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_head           current head entry (valid when !o_empty)
//   o_full, o_empty  occupancy flags
module lu_result_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2  // power of two, >= 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  wr_req_t i_data,
  input  logic    i_pop,
  output wr_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  // Storage needs no reset: entries are only observed through the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline writeback (never back-pressured, highest priority) and results
//   of the long-latency unit, which are buffered in lu_result_fifo.
//   Keeps a per-register busy scoreboard for outstanding long-latency ops and
//   raises a decode stall on hazards or when buffered results starve.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_valid/wb_addr/wb_data      pipeline writeback request
//   lu_valid/lu_ready/lu_addr/lu_data  long-latency result handshake
//   issue_valid/issue_addr        long-latency op dispatched (marks busy)
//   chk_addr1/chk_addr2/chk_dst   decode operands checked against busy
//   stall                         decode stall (combinational)
//   rf_w_en/rf_waddr/rf_wdata     registered register-file write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0]     lu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  input  logic [REG_ADDR_W-1:0] chk_dst,
  output logic                  stall,
  output logic                  rf_w_en,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------
  wr_req_t w_head;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_lu_push;
  logic    w_pop;
  logic    w_wb_sel;

  // lu_ready depends only on fullness, so a full FIFO that is being popped
  // this cycle still refuses the incoming result.
  assign lu_ready  = !w_fifo_full;
  // Address-0 results complete the handshake but are dropped.
  assign w_lu_push = lu_valid && lu_ready && is_live_addr(lu_addr);

  lu_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lu_push),
    .i_data  ('{addr: lu_addr, data: lu_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Arbitration: pipeline writeback first, then FIFO head, else idle
  // ---------------------------------------------------------------------
  wr_req_t w_sel;
  logic    w_sel_vld;

  assign w_wb_sel  = wb_valid && is_live_addr(wb_addr);
  assign w_pop     = !w_wb_sel && !w_fifo_empty;
  assign w_sel_vld = w_wb_sel || w_pop;

  always_comb begin
    w_sel = w_head;
    if (w_wb_sel) w_sel = '{addr: wb_addr, data: wb_data};
  end

  // ---------------------------------------------------------------------
  // Registered write port; address/data hold on idle cycles
  // ---------------------------------------------------------------------
  logic                  r_rf_w_en;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0]     r_rf_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_w_en  <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_w_en <= w_sel_vld;
      if (w_sel_vld) begin
        r_rf_waddr <= w_sel.addr;
        r_rf_wdata <= w_sel.data;
      end
    end
  end

  assign rf_w_en  = r_rf_w_en;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;

  // ---------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------
  // A register goes non-busy on the same edge its result is captured into
  // the write register, so a dependent op can leave decode the cycle the
  // write is presented to the register file.
  logic [REG_COUNT-1:0] r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_pop)
        r_busy[w_head.addr] <= 1'b0;
      if (issue_valid && is_live_addr(issue_addr))
        r_busy[issue_addr] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Starvation: buffered results losing to writeback too long
  // ---------------------------------------------------------------------
  logic [SC_W-1:0] r_starve_cnt;
  logic            w_starve;

  always_ff @(posedge clk) begin
    if (rst || w_pop || w_fifo_empty)
      r_starve_cnt <= '0;
    else if (r_starve_cnt != STARVE_MAX)
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  assign w_starve = (r_starve_cnt == STARVE_MAX);

  // Stalling decode stops new writebacks, letting the FIFO drain.
  logic w_hazard;

  assign w_hazard = (is_live_addr(chk_addr1) && r_busy[chk_addr1]) ||
                    (is_live_addr(chk_addr2) && r_busy[chk_addr2]) ||
                    (is_live_addr(chk_dst)   && r_busy[chk_dst]);
  assign stall    = w_hazard || w_starve;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int FD = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid, issue_valid;
  logic [4:0]  wb_addr, lu_addr, issue_addr, chk_addr1, chk_addr2, chk_dst;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, stall, rf_w_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_dst(chk_dst),
    .stall(stall), .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: lu result buffer contents, expected write stream,
  // busy bits and starve count.
  wr_req_t     luq[$];
  wr_req_t     expq[$];
  logic [31:0] m_busy = '0;
  int          m_scnt = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  typedef struct {
    logic        wbv; logic [4:0] wba; logic [31:0] wbd;
    logic        luv; logic [4:0] lua; logic [31:0] lud;
    logic        isv; logic [4:0] isa;
    logic [4:0]  c1, c2, cd;
    logic        e_stall, e_ready;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    return m_busy[chk_addr1] | m_busy[chk_addr2] | m_busy[chk_dst] | (m_scnt == SL);
  endfunction

  task automatic drv(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                     input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                     input logic isv, input logic [4:0] isa);
    wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    lu_valid = luv; lu_addr = lua; lu_data = lud;
    issue_valid = isv; issue_addr = isa;
  endtask

  task automatic chks(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
    chk_addr1 = a1; chk_addr2 = a2; chk_dst = d;
  endtask

  // One clock: compare combinational outputs against the model mid-cycle,
  // advance the model (pushing the expected write), then pop/compare the
  // registered write port after the edge.
  task automatic step();
    wr_req_t h;
    logic m_wb, m_push, m_pop;
    @(negedge clk);
    if (!rst) begin
      chk("lu_ready", 32'(lu_ready), 32'(luq.size() < FD));
      chk("stall", 32'(stall), 32'(m_stall()));
      if (issue_valid && issue_addr != 0) chk("legal_issue", 32'(m_busy[issue_addr]), 32'd0);
      if (wb_valid && wb_addr != 0) chk("legal_wb", 32'(m_busy[wb_addr]), 32'd0);
      if (lu_valid && lu_ready && lu_addr != 0) chk("legal_lu", 32'(m_busy[lu_addr]), 32'd1);
    end
    if (rst) begin
      luq.delete(); expq.delete();
      m_busy = '0; m_scnt = 0; last_addr = '0; last_data = '0;
    end else begin
      m_wb   = wb_valid && wb_addr != 0;
      m_push = lu_valid && (luq.size() < FD) && lu_addr != 0;
      m_pop  = !m_wb && luq.size() != 0;
      if (m_pop || luq.size() == 0) m_scnt = 0;
      else if (m_scnt < SL) m_scnt++;
      if (m_wb) expq.push_back('{addr: wb_addr, data: wb_data});
      else if (m_pop) begin
        h = luq.pop_front();
        m_busy[h.addr] = 1'b0;
        expq.push_back(h);
      end
      if (m_push) luq.push_back('{addr: lu_addr, data: lu_data});
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
    @(posedge clk); #1;
    if (rf_w_en) begin
      if (expq.size() == 0) chk("unexpected_write", 32'(rf_w_en), 32'd0);
      else begin
        h = expq.pop_front();
        chk("waddr", 32'(rf_waddr), 32'(h.addr));
        chk("wdata", rf_wdata, h.data);
        last_addr = h.addr; last_data = h.data;
      end
    end else begin
      chk("missing_write", 32'(expq.size()), 32'd0);
      expq.delete();
      chk("hold_waddr", 32'(rf_waddr), 32'(last_addr));
      chk("hold_wdata", rf_wdata, last_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wbv   wba    wbd        luv   lua    lud          isv   isa    c1     c2     cd     stl   rdy
    tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5,  32'h1234, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 5'd3, 32'hAA,   1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'd4, 32'hCC,   1'b1, 5'd7,  32'hBB,   1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd3, 32'hAA,   1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 5'd0, 32'h55,   1'b1, 5'd0,  32'h66,   1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1};

    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chks(0, 0, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("reset_lu_ready", 32'(lu_ready), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);

    // Directed single-cycle vectors: busy/pop timing, wb-vs-head priority,
    // address-0 drop.
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].wbv, tbl[i].wba, tbl[i].wbd, tbl[i].luv, tbl[i].lua, tbl[i].lud,
          tbl[i].isv, tbl[i].isa);
      chks(tbl[i].c1, tbl[i].c2, tbl[i].cd);
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_ready", i), 32'(lu_ready), 32'(tbl[i].e_ready));
      step();
    end

    // Fill under continuous writeback, hold a third result, drain in order.
    chks(0, 0, 0);
    drv(1, 1, 32'h1, 0, 0, 0, 1, 10);        step();
    drv(1, 1, 32'h2, 0, 0, 0, 1, 11);        step();
    drv(1, 1, 32'h3, 1, 10, 32'hA0, 1, 12);  step();
    drv(1, 1, 32'h4, 1, 11, 32'hA1, 0, 0);   step();
    drv(1, 2, 32'h5, 1, 12, 32'hA2, 0, 0);   #1;
    chk("full_ready", 32'(lu_ready), 32'd0); step();
    drv(1, 2, 32'h6, 1, 12, 32'hA2, 0, 0);   step();
    drv(0, 0, 0, 1, 12, 32'hA2, 0, 0);       #1;
    chk("full_pop_ready", 32'(lu_ready), 32'd0); step();
    #1;
    chk("after_pop_ready", 32'(lu_ready), 32'd1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);             step(); step();

    // Starvation: one buffered result losing six cycles in a row.
    drv(0, 0, 0, 0, 0, 0, 1, 20);            step();
    drv(0, 0, 0, 1, 20, 32'hB0, 0, 0);       step();
    for (int k = 1; k <= 6; k++) begin
      drv(1, 1, 32'(k), 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("starve_lost%0d", k), 32'(stall), 32'(k >= 5));
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);             #1;
    chk("starve_before_pop", 32'(stall), 32'd1); step();
    #1;
    chk("starve_after_pop", 32'(stall), 32'd0); step();

    // Reset with two buffered results, busy r9 and a writeback in flight.
    drv(0, 0, 0, 0, 0, 0, 1, 9);             step();
    drv(0, 0, 0, 0, 0, 0, 1, 13);            step();
    drv(1, 1, 32'h11, 1, 9, 32'hC0, 0, 0);   step();
    drv(1, 1, 32'h12, 1, 13, 32'hC1, 0, 0);  step();
    rst = 1'b1;
    drv(1, 2, 32'h13, 0, 0, 0, 0, 0);        step();
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chks(9, 13, 0);
    #1;
    chk("rst_mid_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("rst_mid_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_ready", 32'(lu_ready), 32'd1);
    step(); step(); step();

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
